// File: rtl/wc_f55.sv
// wc_f55: fully pipelined 1-D Winograd F(5,5) correlation engine, 4-clock latency.
// Nine evaluation points 0,+-1,+-2,+-3,+-4; the filter transform is built at elaboration.
module wc_f55 #(
    parameter logic signed [9:0] G0 = 10'sd1,
    parameter logic signed [9:0] G1 = 10'sd2,
    parameter logic signed [9:0] G2 = 10'sd3,
    parameter logic signed [9:0] G3 = 10'sd2,
    parameter logic signed [9:0] G4 = 10'sd1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [89:0] D,
    output logic [49:0] Z
);

    function automatic longint pt(input int t);
        return (t % 2 == 1) ? longint'((t + 1) / 2) : -longint'(t / 2);
    endfunction

    function automatic longint tap(input int k);
        return (k == 0) ? longint'(G0) : (k == 1) ? longint'(G1) : (k == 2) ? longint'(G2) :
               (k == 3) ? longint'(G3) : longint'(G4);
    endfunction

    function automatic longint den(input int t);
        longint r;
        r = 1;
        for (int s = 0; s < 9; s++)
            if (s != t) r = r * (pt(t) - pt(s));
        return r;
    endfunction

    function automatic longint lcm9();
        longint l, a, x, y, m;
        l = 1;
        for (int t = 0; t < 9; t++) begin
            a = den(t);
            if (a < 0) a = -a;
            x = l;
            y = a;
            while (y != 0) begin
                m = x % y;
                x = y;
                y = m;
            end
            l = l / x * a;
        end
        return l;
    endfunction

    function automatic int ctz(input longint v);
        int n;
        n = 0;
        while (v % 2 == 0) begin
            v = v / 2;
            n++;
        end
        return n;
    endfunction

    // Newton iteration: an odd o is its own inverse mod 8, each step doubles the valid bits
    function automatic logic [9:0] inv10(input longint o);
        longint x;
        x = o;
        for (int k = 0; k < 3; k++) x = (x * (2 - o * x)) & 1023;
        return 10'(x);
    endfunction

    // Input transform: row t holds the integer numerator of the t-th Lagrange basis polynomial
    function automatic logic [81*32-1:0] bt_tab();
        logic [81*32-1:0] r;
        longint c [9];
        r = '0;
        for (int t = 0; t < 9; t++) begin
            for (int k = 0; k < 9; k++) c[k] = (k == 0) ? 1 : 0;
            for (int s = 0; s < 9; s++)
                if (s != t)
                    for (int k = 8; k >= 0; k--) begin
                        if (k > 0) c[k] = c[k-1] - pt(s) * c[k];
                        else c[k] = -pt(s) * c[k];
                    end
            for (int j = 0; j < 9; j++) r[(t*9+j)*32 +: 32] = 32'(c[j]);
        end
        return r;
    endfunction

    localparam longint L = lcm9();
    localparam int P = ctz(L);
    localparam logic [9:0] INV = inv10(L >> P);

    // Filter transform: g(p_t) scaled by L/den_t so every entry is an integer
    function automatic logic [9*32-1:0] gt_tab();
        logic [9*32-1:0] r;
        longint acc, pw;
        r = '0;
        for (int t = 0; t < 9; t++) begin
            acc = 0;
            pw = 1;
            for (int k = 0; k < 5; k++) begin
                acc = acc + tap(k) * pw;
                pw = pw * pt(t);
            end
            r[t*32 +: 32] = 32'(acc * (L / den(t)));
        end
        return r;
    endfunction

    function automatic logic [45*16-1:0] va_tab();
        logic [45*16-1:0] r;
        longint pw;
        r = '0;
        for (int t = 0; t < 9; t++) begin
            pw = 1;
            for (int i = 0; i < 5; i++) begin
                r[(t*5+i)*16 +: 16] = 16'(pw);
                pw = pw * pt(t);
            end
        end
        return r;
    endfunction

    localparam logic [81*32-1:0] BT = bt_tab();
    localparam logic [9*32-1:0]  GT = gt_tab();
    localparam logic [45*16-1:0] VA = va_tab();

    logic signed [9:0]  d_r [9];
    logic signed [31:0] u_c [9];
    logic signed [31:0] u_r [9];
    logic signed [63:0] m_c [9];
    logic signed [63:0] m_r [9];
    logic signed [63:0] s;
    logic [49:0]        z_c;

    always_comb begin
        for (int t = 0; t < 9; t++) begin
            u_c[t] = '0;
            for (int j = 0; j < 9; j++)
                u_c[t] = u_c[t] + $signed(BT[(t*9+j)*32 +: 32]) * 32'(d_r[j]);
            m_c[t] = 64'(u_r[t]) * 64'($signed(GT[t*32 +: 32]));
        end
    end

    // The sum equals L*y exactly: drop the power-of-two part, then undo the odd part mod 2^10
    always_comb begin
        s = '0;
        z_c = '0;
        for (int i = 0; i < 5; i++) begin
            s = '0;
            for (int t = 0; t < 9; t++)
                s = s + 64'($signed(VA[(t*5+i)*16 +: 16])) * m_r[t];
            z_c[(4-i)*10 +: 10] = 10'(s >>> P) * INV;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int t = 0; t < 9; t++) begin
                d_r[t] <= '0;
                u_r[t] <= '0;
                m_r[t] <= '0;
            end
            Z <= '0;
        end else begin
            for (int t = 0; t < 9; t++) begin
                d_r[t] <= D[(8-t)*10 +: 10];
                u_r[t] <= u_c[t];
                m_r[t] <= m_c[t];
            end
            Z <= z_c;
        end
    end

endmodule

// File: tb/tb_wc_f55.sv
// tb_wc_f55: vector table, random and streaming checks of wc_f55 against a direct correlation model.
module tb_wc_f55;

    typedef int arr9_t [9];
    typedef int arr5_t [5];
    typedef struct {
        logic [89:0] d;
        logic [49:0] z;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [89:0] D;
    logic [49:0] Z;
    int          errors = 0;
    int          checks = 0;
    int          g [5] = '{1, 2, 3, 2, 1};
    logic [49:0] q [$];
    vec_t        vec [6];
    logic [89:0] wa, wb;
    logic [49:0] za, zb;

    wc_f55 dut (.clk(clk), .rst(rst), .D(D), .Z(Z));

    always #5 clk = ~clk;

    function automatic logic [89:0] dpk(input arr9_t a);
        logic [89:0] r;
        for (int k = 0; k < 9; k++) r[(8-k)*10 +: 10] = 10'(a[k]);
        return r;
    endfunction

    function automatic logic [49:0] zpk(input arr5_t a);
        logic [49:0] r;
        for (int i = 0; i < 5; i++) r[(4-i)*10 +: 10] = 10'(a[i]);
        return r;
    endfunction

    // Direct-form correlation, wrapped to 10 bits
    function automatic logic [49:0] ref_z(input logic [89:0] d);
        logic [49:0] r;
        int dv [9];
        int y;
        for (int k = 0; k < 9; k++) dv[k] = int'($signed(d[(8-k)*10 +: 10]));
        for (int i = 0; i < 5; i++) begin
            y = 0;
            for (int k = 0; k < 5; k++) y += dv[i+k] * g[k];
            r[(4-i)*10 +: 10] = 10'(y);
        end
        return r;
    endfunction

    task automatic check(input string nm, input logic [49:0] act, input logic [49:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: Z=%h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock: the model records the window sampled at the edge, Z is compared at the falling edge
    task automatic cyc(input string nm);
        @(posedge clk);
        if (rst) begin
            q.push_back(ref_z(D));
            if (q.size() > 4) void'(q.pop_front());
        end else q.delete();
        @(negedge clk);
        check(nm, Z, (q.size() == 4) ? q[0] : 50'd0);
    endtask

    initial begin
        wa = dpk('{2, -10, 3, 4, -13, -18, -16, -28, -11});
        wb = dpk('{511, 511, 511, 511, 511, 511, 511, 511, 511});
        za = zpk('{-14, -36, -80, -136, -164});
        zb = zpk('{503, 503, 503, 503, 503});
        vec[0] = '{wa, za};
        vec[1] = '{dpk('{1, 0, 0, 0, 0, 0, 0, 0, 0}), zpk('{1, 0, 0, 0, 0})};
        vec[2] = '{dpk('{0, 0, 0, 0, 1, 0, 0, 0, 0}), zpk('{1, 2, 3, 2, 1})};
        vec[3] = '{wb, zb};
        vec[4] = '{dpk('{-512, -512, -512, -512, -512, -512, -512, -512, -512}), zpk('{-512, -512, -512, -512, -512})};
        vec[5] = '{90'd0, 50'd0};

        rst = 1'b1;
        D = '0;
        #2 rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            D = 90'({$urandom(), $urandom(), $urandom()});
            cyc("reset_hold");
        end
        rst = 1'b1;
        D = '0;
        for (int i = 0; i < 5; i++) cyc("release_zero_input");

        for (int v = 0; v < 6; v++) begin
            D = vec[v].d;
            for (int c = 0; c < 6; c++) cyc("table_held");
            check("table_const", Z, vec[v].z);
        end

        for (int i = 0; i < 300; i++) begin
            D = 90'({$urandom(), $urandom(), $urandom()});
            cyc("random");
        end

        for (int k = 0; k < 12; k++) begin
            D = (k % 2 == 0) ? wa : wb;
            cyc("stream");
            if (k >= 3) check("stream_const", Z, ((k - 3) % 2 == 0) ? za : zb);
        end

        #1 rst = 1'b0;
        #1 check("async_clear", Z, 50'd0);
        for (int i = 0; i < 2; i++) begin
            D = 90'({$urandom(), $urandom(), $urandom()});
            cyc("reset_mid");
        end
        rst = 1'b1;
        D = wa;
        for (int k = 0; k < 4; k++) begin
            cyc("after_release");
            if (k < 3) check("release_latency", Z, 50'd0);
            else check("release_first", Z, za);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
